// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen shared types and helpers.
// Lock-state enum, width limit, increment calculator.
package clk_en_gen_pkg;

  localparam int ACC_W_MAX = 32;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Rounded increment for f_out derived from f_ref.
  function automatic logic [ACC_W_MAX-1:0] calc_inc(
    input longint unsigned f_out,
    input longint unsigned f_ref,
    input int              acc_w
  );
    longint unsigned num;
    num = (f_out << acc_w) + (f_ref >> 1);
    return ACC_W_MAX'(num / f_ref);
  endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// clk_en_gen config/status bundle.
// master: cfg_* out, ce_out/locked in; slave is the reverse.
// CLK_EN_GEN_PHASE_EN adds cfg_phase.
interface clk_en_gen_if #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 32
);
  localparam int CH_W =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [ACC_W-1:0]    cfg_inc;
  logic                cfg_sync;
`ifdef CLK_EN_GEN_PHASE_EN
  logic [ACC_W-1:0]    cfg_phase;
`endif
  logic [CHANNELS-1:0] ce_out;
  logic                locked;

`ifdef CLK_EN_GEN_PHASE_EN
  modport master (
    output cfg_we, cfg_ch, cfg_inc,
    output cfg_sync, cfg_phase,
    input  ce_out, locked
  );
  modport slave (
    input  cfg_we, cfg_ch, cfg_inc,
    input  cfg_sync, cfg_phase,
    output ce_out, locked
  );
`else
  modport master (
    output cfg_we, cfg_ch, cfg_inc, cfg_sync,
    input  ce_out, locked
  );
  modport slave (
    input  cfg_we, cfg_ch, cfg_inc, cfg_sync,
    output ce_out, locked
  );
`endif

endinterface

// File: rtl/clk_en_gen_chan.sv
// One phase-accumulator enable channel.
// Ports: clk, rst_n, we, inc_in, sync,
// [phase_in with CLK_EN_GEN_PHASE_EN], ce, pend.
module clk_en_chan
  import clk_en_gen_pkg::*;
#(
  parameter int                   ACC_W       = 32,
  parameter logic [ACC_W_MAX-1:0] DEFAULT_INC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             sync,
`ifdef CLK_EN_GEN_PHASE_EN
  input  logic [ACC_W-1:0] phase_in,
`endif
  output logic             ce,
  output logic             pend
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] pinc_q, pinc_d;
  logic             pend_q, pend_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  logic             commit;
`ifdef CLK_EN_GEN_PHASE_EN
  logic [ACC_W-1:0] ph_q, ph_d;
`endif

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d  = sum[ACC_W-1:0];
    ce_d   = sum[ACC_W];
    inc_d  = inc_q;
    pinc_d = pinc_q;
    pend_d = pend_q;
    // Swap only at a carry (or when idle / aligning)
    // so no pulse is split between two rates.
    commit = pend_q &&
             (sum[ACC_W] || (inc_q == '0) || sync);
    if (sync) begin
`ifdef CLK_EN_GEN_PHASE_EN
      acc_d = ph_q;
`else
      acc_d = '0;
`endif
      ce_d  = 1'b0;
    end
    if (commit) begin
      inc_d  = pinc_q;
      pend_d = 1'b0;
    end
    // A same-cycle write re-arms pending after commit.
    if (we) begin
      pinc_d = inc_in;
      pend_d = 1'b1;
    end
  end

`ifdef CLK_EN_GEN_PHASE_EN
  always_comb begin
    ph_d = ph_q;
    if (we) ph_d = phase_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ph_q <= '0;
    else        ph_q <= ph_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      inc_q  <= ACC_W'(DEFAULT_INC);
      pinc_q <= '0;
      pend_q <= 1'b0;
      ce_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      pinc_q <= pinc_d;
      pend_q <= pend_d;
      ce_q   <= ce_d;
    end
  end

  assign ce   = ce_q;
  assign pend = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator top.
// Ports: refclk, rst_n, bus (slave: cfg_* in,
// ce_out/locked out). CLK_EN_GEN_PHASE_EN adds phase.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int                   CHANNELS    = 2,
  parameter int                   ACC_W       = 32,
  parameter logic [ACC_W_MAX-1:0] DEFAULT_INC =
    calc_inc(64'd7_000_000, 64'd42_000_000, 32),
  parameter int                   LOCK_CYCLES = 16
) (
  input  logic        refclk,
  input  logic        rst_n,
  clk_en_gen_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic [CHANNELS-1:0] ce;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] we_ch;
  logic                acc_wr;

  lock_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    acc_wr = bus.cfg_we &&
             (32'(bus.cfg_ch) < 32'(CHANNELS));
    we_ch  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      we_ch[i] = acc_wr &&
                 (32'(bus.cfg_ch) == 32'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clk_en_chan #(
      .ACC_W       (ACC_W),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_chan (
      .clk      (refclk),
      .rst_n    (rst_n),
      .we       (we_ch[g]),
      .inc_in   (bus.cfg_inc),
      .sync     (bus.cfg_sync),
`ifdef CLK_EN_GEN_PHASE_EN
      .phase_in (bus.cfg_phase),
`endif
      .ce       (ce[g]),
      .pend     (pend[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SETTLE: begin
        if (|pend) begin
          cnt_d = '0;
        end else if (cnt_q ==
                     CNT_W'(LOCK_CYCLES - 1)) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (acc_wr || bus.cfg_sync) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ce_out = ce;
  assign bus.locked = (state_q == LOCKED);

endmodule
